sdram_req_queue: RTL and testbench
==================================

// Module: sdram_req_queue
// PURPOSE
//  Client-facing request queue directly upstream of sdram_ctrl.
//  - Buffers write/read requests from one client behind a valid/ready handshake.
//  - Issues them one at a time as single-cycle app_req pulses.
//  - Enforces the controller's inter-request gap after writes.
//  - Waits for app_rvalid after each read and returns the data on a response port.
// PARAMETERS
//  DATA_W      16   data width, equal to sdram_ctrl DATA_W
//  ADDR_W      24   linear app address width, equal to sdram_ctrl APP_AW
//  DQM_W       DATA_W/8 (min 1)  byte-mask width
//  DEPTH       4    request FIFO entries; power of 2, >=2
//  WR_GAP      8    idle cycles after a write pulse before the next app_req; >=1
//  RD_TIMEOUT  64   read-wait limit in cycles (used only with SDRAM_REQ_TIMEOUT_EN)
// PORTS
//  clk        in   1                  single clock
//  rst        in   1                  asynchronous reset, active-high
//  req_valid  in   1                  client request valid
//  req_ready  out  1                  queue can accept (not full)
//  req_we     in   1                  1=write, 0=read
//  req_addr   in   ADDR_W             linear address
//  req_wdata  in   DATA_W             write data
//  req_dqm    in   DQM_W              write byte mask (1=masked)
//  rsp_valid  out  1                  one-cycle read response strobe; no backpressure
//  rsp_data   out  DATA_W             read data
//  rsp_err    out  1                  read timed out (0 when timeout is compiled out)
//  app_req    out  1                  one-cycle request pulse to sdram_ctrl
//  app_we     out  1                  to sdram_ctrl
//  app_addr   out  ADDR_W             to sdram_ctrl
//  app_wdata  out  DATA_W             to sdram_ctrl
//  app_dqm    out  DQM_W              to sdram_ctrl
//  app_rdata  in   DATA_W             from sdram_ctrl
//  app_rvalid in   1                  from sdram_ctrl; read data valid
//  level      out  $clog2(DEPTH)+1    FIFO occupancy
// BEHAVIOUR
//  Reset (async, rst=1):
//   - All outputs go to 0, except req_ready, which goes to 1.
//   - FIFO is emptied, FSM goes to IDLE, counters clear.
//   - An in-flight request is dropped; no response is produced for it.
//  FIFO:
//   - Push when req_valid && req_ready. Pop only on the IDLE->ISSUE transition.
//   - req_ready = (level != DEPTH), registered-free. A push to a full FIFO is impossible.
//   - Push and pop in the same cycle leave level unchanged.
//   - Pointers wrap modulo DEPTH.
//  FSM, states IDLE, ISSUE, WGAP, RWAIT:
//   - IDLE: if FIFO non-empty, pop head into registered app_* outputs and go to ISSUE.
//   - ISSUE: app_req=1 for exactly this cycle. Go to WGAP if app_we, else to RWAIT.
//   - WGAP: load counter with WR_GAP, decrement each cycle, go to IDLE when it reaches 0.
//   - RWAIT: on app_rvalid, register rsp_data=app_rdata and rsp_valid=1 next cycle, rsp_err=0, go to IDLE.
//  Timing:
//   - Push into an empty queue at edge N (FSM idle): app_req high in cycle N+1.
//   - Back-to-back writes: app_req pulses are WR_GAP+2 cycles apart.
//   - Read: app_rvalid at cycle R gives rsp_valid at R+1; the next app_req is no earlier than R+2.
//  Outputs when not active:
//   - app_* hold the last issued values; only app_req qualifies them.
//   - app_rvalid outside RWAIT is ignored.
//  Order: requests are issued strictly in arrival order; at most one request is outstanding.
// CONFIGURATION
//  SDRAM_REQ_TIMEOUT_EN defined:
//   - RWAIT counts cycles from entry.
//   - After RD_TIMEOUT cycles without app_rvalid: rsp_valid=1, rsp_err=1, rsp_data=0, go to IDLE.
//   - A late app_rvalid after the timeout is ignored.
//  SDRAM_REQ_TIMEOUT_EN undefined: RWAIT waits indefinitely; rsp_err is tied to 0.
// STRUCTURE
//  Package sdram_pkg:
//   - req_t struct {we, addr, wdata, dqm}
//   - state_t enum {IDLE, ISSUE, WGAP, RWAIT}
//  Sub-module sdram_req_fifo: synchronous FIFO of req_t.
//   - DEPTH parameter, async active-high rst.
//   - push/pop/full/empty/level ports.
//  FSM, gap/timeout counter and response registers live in the top module.
// TESTING
//  - Reset: assert rst mid-RWAIT -> all outputs 0 and req_ready=1 in the same cycle; no rsp_valid after release.
//  - Single write: addr=0x000010, data=0xA5A5, dqm=0 into empty queue -> one app_req pulse 1 cycle later, app_we=1, fields match.
//  - Write gap: 3 writes pushed back-to-back with WR_GAP=8 -> app_req pulses exactly 10 cycles apart, in order.
//  - Full: hold app_rvalid=0 and push reads until req_ready=0 -> level=DEPTH; an extra valid is not accepted.
//  - Read: app_rvalid with app_rdata=0x1234, 5 cycles after app_req -> rsp_valid next cycle, rsp_data=0x1234, rsp_err=0.
//  - Timeout (macro on, RD_TIMEOUT=64): no app_rvalid -> rsp_valid with rsp_err=1, rsp_data=0 after 64 RWAIT cycles; the queue resumes.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM client request queue.
// req_t is the request record at the default widths (16-bit data, 24-bit address);
// the queue top builds its own record at its parameterised widths.
package sdram_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DQM_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WGAP  = 2'd2,
    RWAIT = 2'd3
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_DQM_W-1:0]  dqm;
  } req_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous request FIFO. DEPTH must be a power of two so the pointers wrap
// naturally. Push into a full FIFO and pop from an empty one are ignored.
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = req_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/sdram_req_queue.sv
// Client request queue in front of sdram_ctrl: buffers requests, issues them
// one at a time as app_req pulses, spaces writes by WR_GAP idle cycles and
// waits for app_rvalid after each read.
// Optional macro SDRAM_REQ_TIMEOUT_EN: abandon a read after RD_TIMEOUT cycles
// in RWAIT and answer it with rsp_err=1.
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 24,
  parameter int DQM_W      = (DATA_W / 8 < 1) ? 1 : DATA_W / 8,
  parameter int DEPTH      = 4,
  parameter int WR_GAP     = 8,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DQM_W-1:0]         req_dqm,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     app_req,
  output logic                     app_we,
  output logic [ADDR_W-1:0]        app_addr,
  output logic [DATA_W-1:0]        app_wdata,
  output logic [DQM_W-1:0]         app_dqm,
  input  logic [DATA_W-1:0]        app_rdata,
  input  logic                     app_rvalid,
  output logic [$clog2(DEPTH):0]   level
);

  // One counter serves both the write gap and the read timeout.
  localparam int CNT_MAX = (WR_GAP > RD_TIMEOUT) ? WR_GAP : RD_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DQM_W-1:0]  dqm;
  } qreq_t;

  qreq_t fifo_din, fifo_head;
  logic  fifo_full, fifo_empty, fifo_push, fifo_pop;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              app_req_q, app_req_d;
  logic              app_we_q, app_we_d;
  logic [ADDR_W-1:0] app_addr_q, app_addr_d;
  logic [DATA_W-1:0] app_wdata_q, app_wdata_d;
  logic [DQM_W-1:0]  app_dqm_q, app_dqm_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
`ifdef SDRAM_REQ_TIMEOUT_EN
  logic              rsp_err_q, rsp_err_d;
`endif

  assign req_ready = ~fifo_full;
  assign fifo_push = req_valid & req_ready;
  assign fifo_din  = '{we: req_we, addr: req_addr, wdata: req_wdata, dqm: req_dqm};

  sdram_req_fifo #(.DEPTH(DEPTH), .T(qreq_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Issue FSM: next state, counter, app_* capture and read response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fifo_pop    = 1'b0;
    app_req_d   = 1'b0;
    app_we_d    = app_we_q;
    app_addr_d  = app_addr_q;
    app_wdata_d = app_wdata_q;
    app_dqm_d   = app_dqm_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`ifdef SDRAM_REQ_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          app_req_d   = 1'b1;
          app_we_d    = fifo_head.we;
          app_addr_d  = fifo_head.addr;
          app_wdata_d = fifo_head.wdata;
          app_dqm_d   = fifo_head.dqm;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (app_we_q) begin
          state_d = WGAP;
          cnt_d   = CW'(WR_GAP);
        end else begin
          state_d = RWAIT;
          cnt_d   = '0;
        end
      end
      WGAP: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      RWAIT: begin
        if (app_rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = app_rdata;
`ifdef SDRAM_REQ_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = IDLE;
        end
`ifdef SDRAM_REQ_TIMEOUT_EN
        else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      app_req_q   <= 1'b0;
      app_we_q    <= 1'b0;
      app_addr_q  <= '0;
      app_wdata_q <= '0;
      app_dqm_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      app_req_q   <= app_req_d;
      app_we_q    <= app_we_d;
      app_addr_q  <= app_addr_d;
      app_wdata_q <= app_wdata_d;
      app_dqm_q   <= app_dqm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef SDRAM_REQ_TIMEOUT_EN
  // Error flag register, present only with the timeout feature.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_err_q <= 1'b0;
    else     rsp_err_q <= rsp_err_d;
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign app_req   = app_req_q;
  assign app_we    = app_we_q;
  assign app_addr  = app_addr_q;
  assign app_wdata = app_wdata_q;
  assign app_dqm   = app_dqm_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue (WR_GAP=8, DEPTH=4). The read-timeout
// section runs only when SDRAM_REQ_TIMEOUT_EN is defined.
module tb_sdram_req_queue;

  localparam int DATA_W = 16, ADDR_W = 24, DQM_W = 2, DEPTH = 4;
  localparam int WR_GAP = 8, RD_TIMEOUT = 64, LW = 3;

  logic              clk = 1'b0, rst = 1'b1;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DQM_W-1:0]  req_dqm;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic              app_req, app_we, app_rvalid;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_wdata, app_rdata;
  logic [DQM_W-1:0]  app_dqm;
  logic [LW-1:0]     level;

  sdram_req_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DQM_W(DQM_W), .DEPTH(DEPTH),
    .WR_GAP(WR_GAP), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_dqm(req_dqm),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .app_req(app_req), .app_we(app_we), .app_addr(app_addr),
    .app_wdata(app_wdata), .app_dqm(app_dqm),
    .app_rdata(app_rdata), .app_rvalid(app_rvalid), .level(level)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0, cyc = 0;
  int                p_cyc  [$];
  logic [ADDR_W-1:0] p_addr [$];
  logic              p_we   [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every app_req pulse with the cycle it occurred in.
  always @(negedge clk)
    if (!rst && app_req) begin
      p_cyc.push_back(cyc);
      p_addr.push_back(app_addr);
      p_we.push_back(app_we);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DQM_W-1:0] m);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_dqm = m;
  endtask

  int acc;

  initial begin
    drive(1'b0, 1'b0, '0, '0, '0);
    app_rvalid = 1'b0;
    app_rdata  = '0;

    // Reset state
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_app_req", app_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Single write into an empty queue
    drive(1'b1, 1'b1, 24'h000010, 16'hA5A5, 2'b00);
    tick();
    req_valid = 1'b0;
    chk("wr1_level_after_push", level, 1);
    chk("wr1_no_req_yet", app_req, 0);
    tick();
    chk("wr1_app_req", app_req, 1);
    chk("wr1_app_we", app_we, 1);
    chk("wr1_app_addr", app_addr, 32'h10);
    chk("wr1_app_wdata", app_wdata, 32'hA5A5);
    chk("wr1_app_dqm", app_dqm, 0);
    chk("wr1_level_after_pop", level, 0);
    tick();
    chk("wr1_req_one_cycle", app_req, 0);
    repeat (12) tick();

    // Three back-to-back writes: pulses WR_GAP+2 apart, in order
    p_cyc.delete(); p_addr.delete(); p_we.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 24'h30 + 24'(i), 16'h1000 + 16'(i), 2'b01);
      tick();
    end
    req_valid = 1'b0;
    repeat (35) tick();
    chk("gap_pulse_count", p_cyc.size(), 3);
    if (p_cyc.size() >= 3) begin
      chk("gap_spacing_0_1", p_cyc[1] - p_cyc[0], WR_GAP + 2);
      chk("gap_spacing_1_2", p_cyc[2] - p_cyc[1], WR_GAP + 2);
      chk("gap_order_0", p_addr[0], 32'h30);
      chk("gap_order_1", p_addr[1], 32'h31);
      chk("gap_order_2", p_addr[2], 32'h32);
      chk("gap_we_2", p_we[2], 1);
    end

    // Read with app_rvalid 5 cycles after app_req
    drive(1'b1, 1'b0, 24'h20, 16'h1002, 2'b01);
    tick();
    req_valid = 1'b0;
    tick();
    chk("rd_app_req", app_req, 1);
    chk("rd_app_we", app_we, 0);
    chk("rd_app_addr", app_addr, 32'h20);
    repeat (4) begin
      tick();
      chk("rd_wait_no_rsp", rsp_valid, 0);
    end
    tick();
    app_rvalid = 1'b1;
    app_rdata  = 16'h1234;
    tick();
    app_rvalid = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_data, 32'h1234);
    chk("rd_rsp_err", rsp_err, 0);
    tick();
    chk("rd_rsp_one_cycle", rsp_valid, 0);

    // Stray app_rvalid while idle is ignored
    repeat (3) tick();
    app_rvalid = 1'b1;
    app_rdata  = 16'hBEEF;
    tick();
    app_rvalid = 1'b0;
    tick();
    chk("stray_rvalid_no_rsp", rsp_valid, 0);
    chk("stray_rvalid_data_held", rsp_data, 32'h1234);

    // Fill the queue while the first read hangs in RWAIT
    acc = 0;
    drive(1'b1, 1'b0, 24'h100, 16'h1002, 2'b01);
    for (int i = 0; i < 10 && req_ready; i++) begin
      req_addr = 24'h100 + 24'(acc);
      acc++;
      tick();
    end
    chk("full_accepted", acc, DEPTH + 1);
    chk("full_ready_low", req_ready, 0);
    chk("full_level", level, DEPTH);
    repeat (2) tick();
    chk("full_extra_rejected", level, DEPTH);
    chk("full_inflight_addr", app_addr, 32'h100);

    // Asynchronous reset mid-RWAIT
    #2;
    rst = 1'b1;
    #1;
    chk("arst_app_req", app_req, 0);
    chk("arst_app_addr", app_addr, 0);
    chk("arst_app_wdata", app_wdata, 0);
    chk("arst_app_dqm", app_dqm, 0);
    chk("arst_rsp_data", rsp_data, 0);
    chk("arst_level", level, 0);
    chk("arst_ready", req_ready, 1);
    req_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();
    app_rvalid = 1'b1;
    app_rdata  = 16'h5555;
    tick();
    app_rvalid = 1'b0;
    repeat (3) begin
      chk("arst_no_rsp", rsp_valid, 0);
      chk("arst_no_req", app_req, 0);
      tick();
    end

    // Queue resumes with a fresh request after reset
    drive(1'b1, 1'b1, 24'h55, 16'h0F0F, 2'b10);
    tick();
    req_valid = 1'b0;
    tick();
    chk("resume_app_req", app_req, 1);
    chk("resume_app_addr", app_addr, 32'h55);
    repeat (12) tick();

`ifdef SDRAM_REQ_TIMEOUT_EN
    // Read timeout after RD_TIMEOUT cycles in RWAIT
    drive(1'b1, 1'b0, 24'h77, 16'h0, 2'b00);
    tick();
    req_valid = 1'b0;
    tick();
    chk("to_app_req", app_req, 1);
    repeat (RD_TIMEOUT) tick();
    chk("to_not_yet", rsp_valid, 0);
    tick();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    app_rvalid = 1'b1;
    app_rdata  = 16'hDEAD;
    tick();
    app_rvalid = 1'b0;
    chk("to_late_rvalid_ignored", rsp_valid, 0);
    drive(1'b1, 1'b1, 24'h78, 16'h1, 2'b00);
    tick();
    req_valid = 1'b0;
    tick();
    chk("to_resume_req", app_req, 1);
    chk("to_resume_addr", app_addr, 32'h78);
    repeat (12) tick();
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
